// File: rtl/tinyqv_alu_pkg.sv
// Shared types and constants for the nibble-serial ALU and its word sequencer.
package tinyqv_alu_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  localparam int NIBBLES = 8;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int SUB_BIT = 3;

endpackage

// File: rtl/tinyqv_alu.sv
// One 4-bit slice of the serial ALU: add/sub, logic ops, and the carry and
// compare chains that the sequencer threads from slice to slice.
module tinyqv_alu
  import tinyqv_alu_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cy_i,
  input  logic       cmp_i,
  output logic [3:0] d_o,
  output logic       cy_o,
  output logic       cmp_o
);

  logic       invert_b;
  logic [4:0] sum;
  logic       lt;

  always_comb begin
    invert_b = op_i[1] | op_i[SUB_BIT];
    sum      = {1'b0, a_i} + {1'b0, (invert_b ? ~b_i : b_i)} + {4'b0, cy_i};
    cy_o     = sum[4];

    case (op_i[2:0])
      F3_XOR:  d_o = a_i ^ b_i;
      F3_OR:   d_o = a_i | b_i;
      F3_AND:  d_o = a_i & b_i;
      default: d_o = sum[3:0];
    endcase

    // Only meaningful on the top slice: signed compare looks at the sign bits
    // when they differ, otherwise a borrow out of a-b means a<b.
    if (!op_i[0] && (a_i[3] != b_i[3])) begin
      lt = a_i[3];
    end else begin
      lt = ~sum[4];
    end

    if (op_i[2:1] == F3_SLT[2:1]) begin
      cmp_o = lt;
    end else begin
      cmp_o = cmp_i & (d_o == 4'h0);
    end
  end

endmodule

// File: rtl/tinyqv_alu_seq.sv
// Word sequencer for the serial ALU with optional two-port round-robin front end.
// Define TINYQV_ALU_SEQ_ARB_EN to enable port 1 and the arbiter.
module tinyqv_alu_seq
  import tinyqv_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_d,
  output logic        rsp_cmp,
  output logic        rsp_id,
  output logic        busy
);

  seq_state_e  state_q, state_d;
  logic [2:0]  nib_q, nib_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        cy_q, cy_d;
  logic        cmp_q, cmp_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_cmp_q, rsp_cmp_d;
  logic        rsp_id_q, rsp_id_d;

  logic        accept;
  logic        grant;
  logic        hs;
  logic [3:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_cy_in;
  logic        alu_cmp_in;
  logic [3:0]  alu_d;
  logic        alu_cy_out;
  logic        alu_cmp_out;

  assign accept = !rst && ((state_q == SEQ_IDLE) || ((state_q == SEQ_DONE) && rsp_ready));

`ifdef TINYQV_ALU_SEQ_ARB_EN
  logic last_grant_q;

  // On a tie the port that lost last time wins; a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign hs         = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign sel_op     = grant ? req1_op : req0_op;
  assign sel_a      = grant ? req1_a  : req0_a;
  assign sel_b      = grant ? req1_b  : req0_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (hs) begin
      last_grant_q <= grant;
    end
  end
`else
  logic unused_req1;
  assign unused_req1 = ^{req1_valid, req1_op, req1_a, req1_b};

  assign grant      = 1'b0;
  assign req0_ready = accept;
  assign req1_ready = 1'b0;
  assign hs         = accept && req0_valid;
  assign sel_op     = req0_op;
  assign sel_a      = req0_a;
  assign sel_b      = req0_b;
`endif

  always_comb begin
    alu_a      = a_q[{nib_q, 2'b00} +: 4];
    alu_b      = b_q[{nib_q, 2'b00} +: 4];
    alu_cy_in  = (nib_q == 3'd0) ? (op_q[1] | op_q[SUB_BIT]) : cy_q;
    alu_cmp_in = (nib_q == 3'd0) ? 1'b1 : cmp_q;
  end

  tinyqv_alu u_alu (
    .op_i  (op_q),
    .a_i   (alu_a),
    .b_i   (alu_b),
    .cy_i  (alu_cy_in),
    .cmp_i (alu_cmp_in),
    .d_o   (alu_d),
    .cy_o  (alu_cy_out),
    .cmp_o (alu_cmp_out)
  );

  always_comb begin
    state_d    = state_q;
    nib_d      = nib_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cy_d       = cy_q;
    cmp_d      = cmp_q;
    rsp_data_d = rsp_data_q;
    rsp_cmp_d  = rsp_cmp_q;
    rsp_id_d   = rsp_id_q;

    case (state_q)
      SEQ_IDLE: ;
      SEQ_RUN: begin
        rsp_data_d[{nib_q, 2'b00} +: 4] = alu_d;
        cy_d  = alu_cy_out;
        cmp_d = alu_cmp_out;
        nib_d = nib_q + 3'd1;
        if (nib_q == 3'(NIBBLES - 1)) begin
          // Set-less-than ops return the compare bit as the whole word.
          if (op_q[2:1] == F3_SLT[2:1]) begin
            rsp_data_d = {31'b0, alu_cmp_out};
          end
          rsp_cmp_d = alu_cmp_out;
          state_d   = SEQ_DONE;
        end
      end
      SEQ_DONE: begin
        if (rsp_ready) begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase

    // A new request may be taken in the same cycle the previous result leaves.
    if (hs) begin
      op_d       = sel_op;
      a_d        = sel_a;
      b_d        = sel_b;
      rsp_id_d   = grant;
      nib_d      = 3'd0;
      rsp_data_d = 32'h0;
      state_d    = SEQ_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      nib_q      <= 3'd0;
      op_q       <= 4'h0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      cy_q       <= 1'b0;
      cmp_q      <= 1'b0;
      rsp_data_q <= 32'h0;
      rsp_cmp_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_q      <= nib_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cy_q       <= cy_d;
      cmp_q      <= cmp_d;
      rsp_data_q <= rsp_data_d;
      rsp_cmp_q  <= rsp_cmp_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == SEQ_DONE);
  assign rsp_d     = rsp_data_q;
  assign rsp_cmp   = rsp_cmp_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != SEQ_IDLE);

endmodule
